apb_gpio_bridge: RTL and testbench

APB_GPIO_BRIDGE -- requirements
Module: apb_gpio_bridge

---
 rtl/apb_gpio_pkg.sv | 28 ++
 rtl/apb_gpio_bridge_if.sv | 23 ++
 rtl/apb_gpio_bridge.sv | 108 ++++++++++
 tb/tb_apb_gpio_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_pkg.sv
// Shared types for the APB-to-GPIO register bridge: FSM states, register-select
// encodings and the setup-phase error decode.
package apb_gpio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WR      = 2'b01,
        ST_RD_WAIT = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

    localparam logic [1:0] REG_PIN       = 2'b00;
    localparam logic [1:0] REG_PIN_ALIAS = 2'b01;
    localparam logic [1:0] REG_DIR       = 2'b10;
    localparam logic [1:0] REG_PORT      = 2'b11;

    localparam int CNT_W = 3;

    // Misaligned addresses fail, as do writes to the read-only PIN slots.
    function automatic logic setup_error(input logic [3:0] addr, input logic write);
        logic misaligned;
        logic ro_write;
        misaligned = (addr[1:0] != 2'b00);
        ro_write   = write && ((addr[3:2] == REG_PIN) || (addr[3:2] == REG_PIN_ALIAS));
        return misaligned || ro_write;
    endfunction

endpackage

// File: rtl/apb_gpio_bridge_if.sv
// APB slave-side signal bundle for the GPIO bridge.
interface apb_gpio_bridge_if;

    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [3:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_gpio_bridge.sv
// APB slave that turns each transfer into one GPIO register-bus access,
// with a programmable read latency and fully registered outputs.
module apb_gpio_bridge
    import apb_gpio_pkg::*;
#(
    parameter int READ_WAIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    apb_gpio_bridge_if.slave    apb,
    output logic                BUSW,
    output logic [7:0]          BUSWDATA,
    output logic [1:0]          REGSEL,
    input  logic [7:0]          BUSRDATA
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_WAIT);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       prdata_q;
    logic             pready_q;
    logic             pslverr_q;
    logic             busw_q;
    logic [7:0]       buswdata_q;
    logic [1:0]       regsel_q;

    logic             setup_d;
    logic             err_d;

    always_comb begin
        setup_d = apb.PSEL && !apb.PENABLE;
        err_d   = setup_error(apb.PADDR, apb.PWRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            prdata_q   <= 8'h00;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            busw_q     <= 1'b0;
            buswdata_q <= 8'h00;
            regsel_q   <= REG_PIN;
        end else begin
            busw_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (setup_d) begin
                        if (err_d) begin
                            state_q   <= ST_RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            prdata_q  <= 8'h00;
                        end else if (apb.PWRITE) begin
                            state_q    <= ST_WR;
                            busw_q     <= 1'b1;
                            regsel_q   <= apb.PADDR[3:2];
                            buswdata_q <= apb.PWDATA;
                        end else begin
                            state_q  <= ST_RD_WAIT;
                            regsel_q <= apb.PADDR[3:2];
                            cnt_q    <= WAIT_LOAD;
                        end
                    end
                end
                // The strobe has already been issued; finish regardless of PSEL.
                ST_WR: begin
                    state_q   <= ST_RESP;
                    pready_q  <= 1'b1;
                    pslverr_q <= 1'b0;
                end
                ST_RD_WAIT: begin
                    if (!apb.PSEL) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q   <= ST_RESP;
                        prdata_q  <= BUSRDATA;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (!apb.PSEL || apb.PENABLE) begin
                        state_q   <= ST_IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign BUSW        = busw_q;
    assign BUSWDATA    = buswdata_q;
    assign REGSEL      = regsel_q;

endmodule

// File: tb/tb_apb_gpio_bridge.sv
// Bench for apb_gpio_bridge: two bridges (READ_WAIT=1 and 3), each with a small
// GPIO register model, driven by an APB master task.
module tb_apb_gpio_bridge;
    import apb_gpio_pkg::*;

    typedef struct {
        int         gap;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_waits;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         waits;
        int         pulses;
        logic [1:0] regsel;
        logic [7:0] wdata;
    } exp_t;

    localparam logic [7:0] PINS = 8'h5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       mrst;
    logic       psel, penable, pwrite, use2;
    logic [3:0] paddr;
    logic [7:0] pwdata;

    apb_gpio_bridge_if apb1 ();
    apb_gpio_bridge_if apb2 ();

    logic       busw1, busw2;
    logic [7:0] bwd1, bwd2;
    logic [1:0] rs1, rs2;
    logic [7:0] brd1, brd2;
    logic [7:0] dir1, port1, dir2, port2;

    assign apb1.PSEL    = psel & ~use2;
    assign apb2.PSEL    = psel & use2;
    assign apb1.PENABLE = penable;
    assign apb2.PENABLE = penable;
    assign apb1.PWRITE  = pwrite;
    assign apb2.PWRITE  = pwrite;
    assign apb1.PADDR   = paddr;
    assign apb2.PADDR   = paddr;
    assign apb1.PWDATA  = pwdata;
    assign apb2.PWDATA  = pwdata;

    apb_gpio_bridge #(.READ_WAIT(1)) dut1 (
        .clk(clk), .rst(rst), .apb(apb1),
        .BUSW(busw1), .BUSWDATA(bwd1), .REGSEL(rs1), .BUSRDATA(brd1)
    );

    apb_gpio_bridge #(.READ_WAIT(3)) dut2 (
        .clk(clk), .rst(rst), .apb(apb2),
        .BUSW(busw2), .BUSWDATA(bwd2), .REGSEL(rs2), .BUSRDATA(brd2)
    );

    // GPIO register models with a one-cycle registered read
    always @(posedge clk) begin
        if (mrst) begin
            dir1 <= 8'h00; port1 <= 8'h00; brd1 <= 8'h00;
        end else begin
            if (busw1 && rs1 == REG_DIR)  dir1  <= bwd1;
            if (busw1 && rs1 == REG_PORT) port1 <= bwd1;
            brd1 <= (rs1 == REG_DIR) ? dir1 : (rs1 == REG_PORT) ? port1 : PINS;
        end
    end

    always @(posedge clk) begin
        if (mrst) begin
            dir2 <= 8'h00; port2 <= 8'h00; brd2 <= 8'h00;
        end else begin
            if (busw2 && rs2 == REG_DIR)  dir2  <= bwd2;
            if (busw2 && rs2 == REG_PORT) port2 <= bwd2;
            brd2 <= (rs2 == REG_DIR) ? dir2 : (rs2 == REG_PORT) ? port2 : PINS;
        end
    end

    wire       m_pready  = use2 ? apb2.PREADY  : apb1.PREADY;
    wire       m_pslverr = use2 ? apb2.PSLVERR : apb1.PSLVERR;
    wire [7:0] m_prdata  = use2 ? apb2.PRDATA  : apb1.PRDATA;
    wire       m_busw    = use2 ? busw2 : busw1;
    wire [7:0] m_bwd     = use2 ? bwd2  : bwd1;
    wire [1:0] m_rs      = use2 ? rs2   : rs1;

    int         busw_cnt = 0;
    logic [1:0] last_rs;
    logic [7:0] last_wd;

    always @(negedge clk) begin
        if (m_busw) begin
            busw_cnt <= busw_cnt + 1;
            last_rs  <= m_rs;
            last_wd  <= m_bwd;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " PREADY"},   m_pready,  0);
        chk({tag, " PSLVERR"},  m_pslverr, 0);
        chk({tag, " PRDATA"},   m_prdata,  0);
        chk({tag, " BUSW"},     m_busw,    0);
        chk({tag, " BUSWDATA"}, m_bwd,     0);
        chk({tag, " REGSEL"},   m_rs,      0);
    endtask

    // One complete APB transfer starting with the setup phase right now.
    task automatic xfer(input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output logic er, output int waits,
                        output int pulses);
        int c0;
        bit done;
        c0 = busw_cnt;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        done = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            if (m_pready) done = 1'b1;
            else begin
                @(posedge clk); #1;
                waits++;
            end
        end
        chk("pready_timeout", done, 1);
        rd = m_prdata;
        er = m_pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        pulses = busw_cnt - c0;
    endtask

    task automatic check_xfer(input string nm, input logic wr, input logic [3:0] addr,
                              input logic [7:0] wd, input logic [7:0] exp_rd,
                              input logic exp_er, input int exp_w);
        logic [7:0] rd;
        logic er;
        int w, p;
        xfer(wr, addr, wd, rd, er, w, p);
        chk({nm, " PRDATA"},  rd, exp_rd);
        chk({nm, " PSLVERR"}, er, exp_er);
        chk({nm, " waits"},   w,  exp_w);
        chk({nm, " pulses"},  p,  (wr && !exp_er) ? 1 : 0);
    endtask

    vec_t vt[15];
    exp_t sb[$];

    initial begin
        exp_t e, got;
        int w, p;
        logic [7:0] rd;
        logic er;

        vt[0]  = '{1, 1'b1, 4'h8, 8'hA5, 8'h00, 1'b0, 1};
        vt[1]  = '{0, 1'b1, 4'hC, 8'h3C, 8'h00, 1'b0, 1};
        vt[2]  = '{1, 1'b0, 4'hC, 8'h00, 8'h3C, 1'b0, 2};
        vt[3]  = '{0, 1'b0, 4'h8, 8'h00, 8'hA5, 1'b0, 2};
        vt[4]  = '{0, 1'b1, 4'h0, 8'hFF, 8'h00, 1'b1, 0};
        vt[5]  = '{1, 1'b0, 4'hC, 8'h00, 8'h3C, 1'b0, 2};
        vt[6]  = '{2, 1'b1, 4'h9, 8'h55, 8'h00, 1'b1, 0};
        vt[7]  = '{0, 1'b0, 4'h0, 8'h00, PINS,  1'b0, 2};
        vt[8]  = '{0, 1'b0, 4'h4, 8'h00, PINS,  1'b0, 2};
        vt[9]  = '{1, 1'b0, 4'h2, 8'h00, 8'h00, 1'b1, 0};
        vt[10] = '{0, 1'b0, 4'h0, 8'h00, PINS,  1'b0, 2};
        vt[11] = '{0, 1'b1, 4'h4, 8'h11, 8'h00, 1'b1, 0};
        vt[12] = '{1, 1'b1, 4'h8, 8'h0F, 8'h00, 1'b0, 1};
        vt[13] = '{0, 1'b0, 4'h8, 8'h00, 8'h0F, 1'b0, 2};
        vt[14] = '{0, 1'b1, 4'hC, 8'h99, 8'h0F, 1'b0, 1};

        rst = 1'b1; mrst = 1'b1; use2 = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset dut1");
        use2 = 1'b1;
        chk_reset_outputs("reset dut2");
        use2 = 1'b0;
        rst = 1'b0; mrst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            repeat (vt[i].gap) begin @(posedge clk); #1; end
            e.rdata  = vt[i].exp_rdata;
            e.err    = vt[i].exp_err;
            e.waits  = vt[i].exp_waits;
            e.pulses = (vt[i].wr && !vt[i].exp_err) ? 1 : 0;
            e.regsel = vt[i].addr[3:2];
            e.wdata  = vt[i].wdata;
            sb.push_back(e);
            xfer(vt[i].wr, vt[i].addr, vt[i].wdata, rd, er, w, p);
            got = sb.pop_front();
            chk($sformatf("vec%0d PRDATA", i),  rd, got.rdata);
            chk($sformatf("vec%0d PSLVERR", i), er, got.err);
            chk($sformatf("vec%0d waits", i),   w,  got.waits);
            chk($sformatf("vec%0d pulses", i),  p,  got.pulses);
            if (got.pulses == 1) begin
                chk($sformatf("vec%0d REGSEL", i),   last_rs, got.regsel);
                chk($sformatf("vec%0d BUSWDATA", i), last_wd, got.wdata);
            end
            if (i == 0) chk("model DIR after write", dir1, 8'hA5);
        end

        // Reset while waiting on a read
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'hC;
        @(posedge clk); #1;
        penable = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("rst in RD_WAIT");
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check_xfer("read after rst RD_WAIT", 1'b0, 4'hC, 8'h00, 8'h99, 1'b0, 2);

        // Reset during the write strobe
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'hC; pwdata = 8'h77;
        @(posedge clk); #1;
        chk("WR strobe high", m_busw, 1);
        penable = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("rst in WR");
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check_xfer("read after rst WR", 1'b0, 4'hC, 8'h00, 8'h77, 1'b0, 2);

        // Abort in RD_WAIT
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h8;
        @(posedge clk); #1;
        psel = 1'b0;
        @(posedge clk); #1;
        chk("abort RD_WAIT PREADY", m_pready, 0);
        chk("abort RD_WAIT PRDATA", m_prdata, 8'h77);
        @(posedge clk); #1;
        chk("abort RD_WAIT PREADY later", m_pready, 0);
        check_xfer("read after abort", 1'b0, 4'h8, 8'h00, 8'h0F, 1'b0, 2);

        // Abort in RESP after an error
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 8'hEE;
        @(posedge clk); #1;
        chk("err RESP PREADY", m_pready, 1);
        chk("err RESP PSLVERR", m_pslverr, 1);
        psel = 1'b0;
        @(posedge clk); #1;
        chk("abort RESP PREADY", m_pready, 0);
        chk("abort RESP PSLVERR", m_pslverr, 0);
        check_xfer("write after RESP abort", 1'b1, 4'h8, 8'h22, 8'h00, 1'b0, 1);
        check_xfer("read after RESP abort", 1'b0, 4'h8, 8'h00, 8'h22, 1'b0, 2);

        // READ_WAIT=3 instance
        use2 = 1'b1;
        @(posedge clk); #1;
        check_xfer("rw3 write PORT", 1'b1, 4'hC, 8'hC3, 8'h00, 1'b0, 1);
        check_xfer("rw3 read PORT",  1'b0, 4'hC, 8'h00, 8'hC3, 1'b0, 4);
        check_xfer("rw3 read DIR",   1'b0, 4'h8, 8'h00, 8'h00, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
